// File: rtl/idma_chunk_midend.sv
// Default iDMA types, a one-bit-wide outstanding-chunk FIFO and the chunking midend itself.
// Latency: first chunk 1 cycle after request accept; merged response is combinational from the backend.
// Backpressure: new requests stall while splitting; chunks stall on a full outstanding FIFO.
package idma_chunk_midend_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] tf_len_t;

  typedef struct packed {
    logic last;
  } opt_t;

  typedef struct packed {
    tf_len_t length;
    addr_t   src_addr;
    addr_t   dst_addr;
    opt_t    opt;
  } idma_req_t;

  typedef struct packed {
    logic       last;
    logic       error;
    logic [7:0] pld;
  } idma_rsp_t;
endpackage

// Generic FIFO holding one entry per issued chunk.
// Latency: head visible the cycle after push; pop and push may share a cycle.
// Backpressure: a push into a full FIFO is taken only if a pop happens in the same cycle.
module idma_chunk_fifo #(
  parameter int unsigned Depth = 8,
  parameter type         dat_t = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  dat_t push_dat,
  input  logic pop,
  output dat_t head_dat,
  output logic full,
  output logic empty
);
  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] FullCnt = (AW+1)'(Depth);

  dat_t            mem_q [Depth];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic            push_ok, pop_ok;

  assign full     = (cnt_q == FullCnt);
  assign empty    = (cnt_q == '0);
  assign push_ok  = push & (~full | pop);
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
      else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= push_dat;
  end
endmodule

// Splits 1D requests into chunks that never cross a MaxChunkBytes-aligned source boundary.
// Latency: first chunk valid 1 cycle after request accept, then one chunk per cycle.
// Backpressure: at most NumOutstanding chunks in flight; merged response waits on rsp_ready_i.
module idma_chunk_midend #(
  parameter int unsigned MaxChunkBytes  = 256,
  parameter int unsigned NumOutstanding = 8,
  parameter type addr_t     = idma_chunk_midend_pkg::addr_t,
  parameter type tf_len_t   = idma_chunk_midend_pkg::tf_len_t,
  parameter type idma_req_t = idma_chunk_midend_pkg::idma_req_t,
  parameter type idma_rsp_t = idma_chunk_midend_pkg::idma_rsp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  idma_req_t req_i,
  input  logic      req_valid_i,
  output logic      req_ready_o,
  output idma_rsp_t rsp_o,
  output logic      rsp_valid_o,
  input  logic      rsp_ready_i,
  output idma_req_t burst_req_o,
  output logic      burst_req_valid_o,
  input  logic      burst_req_ready_i,
  input  idma_rsp_t burst_rsp_i,
  input  logic      burst_rsp_valid_i,
  output logic      burst_rsp_ready_o,
  output logic      busy_o
);
  localparam int unsigned OffW = $clog2(MaxChunkBytes);
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSplit = 1'b1;

  logic [0:0]     state_q;
  idma_req_t      req_q;
  addr_t          cur_src_q, cur_dst_q;
  tf_len_t        rem_q;
  logic [OffW-1:0] src_off;
  tf_len_t        room, clen;
  logic           chunk_final, chunk_hs;

  logic           fifo_full, fifo_empty, fifo_pop, head_final;
  logic           err_q;
  idma_rsp_t      err_rsp_q;

  // Bytes left until the next aligned boundary bound the chunk; a zero remainder yields one empty chunk.
  assign src_off     = cur_src_q[OffW-1:0];
  assign room        = tf_len_t'(MaxChunkBytes) - tf_len_t'(src_off);
  assign clen        = (rem_q < room) ? rem_q : room;
  assign chunk_final = (clen == rem_q);

  assign req_ready_o       = (state_q == StIdle);
  assign burst_req_valid_o = (state_q == StSplit) & ~fifo_full;
  assign chunk_hs          = burst_req_valid_o & burst_req_ready_i;
  assign busy_o            = (state_q == StSplit) | ~fifo_empty;

  // Chunk request: latched request with the current cursor and chunk length.
  always_comb begin
    burst_req_o          = req_q;
    burst_req_o.src_addr = cur_src_q;
    burst_req_o.dst_addr = cur_dst_q;
    burst_req_o.length   = clen;
    burst_req_o.opt.last = chunk_final & req_q.opt.last;
  end

  // Request acceptance and split cursor; fields only move on a chunk handshake, so they stay stable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      req_q     <= '0;
      cur_src_q <= '0;
      cur_dst_q <= '0;
      rem_q     <= '0;
    end else if (state_q == StIdle) begin
      if (req_valid_i) begin
        req_q     <= req_i;
        cur_src_q <= req_i.src_addr;
        cur_dst_q <= req_i.dst_addr;
        rem_q     <= req_i.length;
        state_q   <= StSplit;
      end
    end else if (chunk_hs) begin
      rem_q     <= rem_q - clen;
      cur_src_q <= cur_src_q + addr_t'(clen);
      cur_dst_q <= cur_dst_q + addr_t'(clen);
      if (chunk_final) state_q <= StIdle;
    end
  end

  idma_chunk_fifo #(
    .Depth (NumOutstanding),
    .dat_t (logic)
  ) i_outstanding (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (chunk_hs),
    .push_dat (chunk_final),
    .pop      (fifo_pop),
    .head_dat (head_final),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Merge: swallow non-final responses, forward the final one with any earlier error folded in.
  always_comb begin
    burst_rsp_ready_o = 1'b0;
    rsp_valid_o       = 1'b0;
    rsp_o             = burst_rsp_i;
    fifo_pop          = 1'b0;
    if (!fifo_empty) begin
      if (!head_final) begin
        burst_rsp_ready_o = 1'b1;
        fifo_pop          = burst_rsp_valid_i;
      end else begin
        burst_rsp_ready_o = rsp_ready_i;
        rsp_valid_o       = burst_rsp_valid_i;
        fifo_pop          = burst_rsp_valid_i & rsp_ready_i;
        if (err_q) begin
          rsp_o      = err_rsp_q;
          rsp_o.last = burst_rsp_i.last;
        end
      end
    end
  end

  // Error latch keeps the first failing chunk response until the merged response leaves.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q     <= 1'b0;
      err_rsp_q <= '0;
    end else if (!fifo_empty && burst_rsp_valid_i) begin
      if (!head_final) begin
        if (burst_rsp_i.error && !err_q) err_rsp_q <= burst_rsp_i;
        err_q <= err_q | burst_rsp_i.error;
      end else if (rsp_ready_i) begin
        err_q <= 1'b0;
      end
    end
  end

  // A backend response with nothing outstanding means the backend broke protocol.
  assert property (@(posedge clk_i) disable iff (rst_i) !(burst_rsp_valid_i && fifo_empty));
endmodule

// File: tb/tb_idma_chunk_midend.sv
// Randomized bench for idma_chunk_midend with a queue-based reference of chunks and merged responses.
// Latency: monitors sample on the falling edge; drivers update 1 time unit after the rising edge.
// Backpressure: backend and downstream ready are randomized, with forced modes for stall scenarios.
module tb_idma_chunk_midend;
  import idma_chunk_midend_pkg::*;

  localparam int unsigned M = 256;

  logic      clk_i = 1'b0;
  logic      rst_i;
  idma_req_t req_i;
  logic      req_valid_i;
  logic      req_ready_o;
  idma_rsp_t rsp_o;
  logic      rsp_valid_o;
  logic      rsp_ready_i;
  idma_req_t burst_req_o;
  logic      burst_req_valid_o;
  logic      burst_req_ready_i;
  idma_rsp_t burst_rsp_i;
  logic      burst_rsp_valid_i;
  logic      burst_rsp_ready_o;
  logic      busy_o;

  always #5 clk_i = ~clk_i;

  idma_chunk_midend #(.MaxChunkBytes(256), .NumOutstanding(8)) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_i             (req_i),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .rsp_o             (rsp_o),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_ready_i       (rsp_ready_i),
    .burst_req_o       (burst_req_o),
    .burst_req_valid_o (burst_req_valid_o),
    .burst_req_ready_i (burst_req_ready_i),
    .burst_rsp_i       (burst_rsp_i),
    .burst_rsp_valid_i (burst_rsp_valid_i),
    .burst_rsp_ready_o (burst_rsp_ready_o),
    .busy_o            (busy_o)
  );

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic        last;
    idma_rsp_t   rsp;
  } chunk_t;

  chunk_t    exp_chunks[$];
  idma_rsp_t exp_rsps[$];
  idma_rsp_t pend[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_chunks = 0;
  bit pause = 1'b0;
  bit force_bready = 1'b0;
  bit hold_rsp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk the transfer boundary by boundary, planning each chunk's backend reply.
  task automatic send_req(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                          input logic opt_last, input int err_idx, input bit rand_err);
    logic [31:0] s, d, rem, room, c;
    bit          fin, have_err, ok;
    int          idx;
    chunk_t      e;
    idma_rsp_t   merged;
    s = src; d = dst; rem = len; idx = 0; have_err = 1'b0; merged = '0;
    do begin
      room = M - (s % M);
      c    = (rem < room) ? rem : room;
      fin  = (c == rem);
      e.src = s; e.dst = d; e.len = c;
      e.last = fin & opt_last;
      e.rsp.last  = e.last;
      e.rsp.error = (idx == err_idx) || (rand_err && $urandom_range(0, 7) == 0);
      e.rsp.pld   = (idx == err_idx) ? 8'hAB : 8'($urandom_range(0, 255));
      if (e.rsp.error && !have_err) begin
        merged   = e.rsp;
        have_err = 1'b1;
      end
      exp_chunks.push_back(e);
      s = s + c; d = d + c; rem = rem - c; idx++;
    end while (!fin);
    if (have_err) merged.last = e.rsp.last;
    else merged = e.rsp;
    exp_rsps.push_back(merged);

    @(posedge clk_i); #1;
    req_valid_i       = 1'b1;
    req_i.src_addr    = src;
    req_i.dst_addr    = dst;
    req_i.length      = len;
    req_i.opt.last    = opt_last;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_i);
      if (req_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    check("req_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_i);
      if (exp_chunks.size() == 0 && exp_rsps.size() == 0 && pend.size() == 0 &&
          !busy_o && !burst_rsp_valid_i) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_drain"}, 64'(ok), 64'd1);
  endtask

  // Chunk monitor: compare every accepted chunk and queue its planned backend reply.
  chunk_t mon_c;
  always @(negedge clk_i) begin
    if (!rst_i && burst_req_valid_o && burst_req_ready_i) begin
      n_chunks++;
      if (exp_chunks.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL chunk_unexpected actual src=0x%0h len=0x%0h required none",
                 burst_req_o.src_addr, burst_req_o.length);
      end else begin
        mon_c = exp_chunks.pop_front();
        check("chunk_src",  64'(burst_req_o.src_addr), 64'(mon_c.src));
        check("chunk_dst",  64'(burst_req_o.dst_addr), 64'(mon_c.dst));
        check("chunk_len",  64'(burst_req_o.length),   64'(mon_c.len));
        check("chunk_last", 64'(burst_req_o.opt.last), 64'(mon_c.last));
        pend.push_back(mon_c.rsp);
      end
    end
  end

  // Merged response monitor.
  idma_rsp_t mon_r;
  always @(negedge clk_i) begin
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      if (exp_rsps.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rsp_unexpected actual=0x%0h required none", rsp_o);
      end else begin
        mon_r = exp_rsps.pop_front();
        check("rsp_error", 64'(rsp_o.error), 64'(mon_r.error));
        check("rsp_pld",   64'(rsp_o.pld),   64'(mon_r.pld));
        check("rsp_last",  64'(rsp_o.last),  64'(mon_r.last));
      end
    end
  end

  // Backend responder: replies in issue order with random gaps, holding valid until taken.
  bit bdone;
  initial begin
    burst_rsp_valid_i = 1'b0;
    burst_rsp_i       = '0;
    forever begin
      @(negedge clk_i);
      bdone = 1'b0;
      if (burst_rsp_valid_i && burst_rsp_ready_o) begin
        void'(pend.pop_front());
        bdone = 1'b1;
      end
      @(posedge clk_i); #1;
      if (!burst_rsp_valid_i || bdone) begin
        if (!pause && pend.size() > 0 && $urandom_range(0, 3) != 0) begin
          burst_rsp_valid_i = 1'b1;
          burst_rsp_i       = pend[0];
        end else begin
          burst_rsp_valid_i = 1'b0;
        end
      end
    end
  end

  // Ready generators with forced modes.
  initial begin
    burst_req_ready_i = 1'b0;
    rsp_ready_i       = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      burst_req_ready_i = force_bready | ($urandom_range(0, 3) != 0);
      rsp_ready_i       = !hold_rsp && ($urandom_range(0, 3) != 0);
    end
  end

  int  base;
  bit  got;
  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_i       = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_req_ready",   64'(req_ready_o),       64'd1);
    check("rst_burst_valid", 64'(burst_req_valid_o), 64'd0);
    check("rst_rsp_valid",   64'(rsp_valid_o),       64'd0);
    check("rst_busy",        64'(busy_o),            64'd0);
    check("rst_brsp_ready",  64'(burst_rsp_ready_o), 64'd0);

    // Aligned 1 KiB: four full chunks, last flag only on the fourth.
    send_req(32'h0, 32'h4000, 32'd1024, 1'b1, -1, 1'b0);
    drain("aligned");

    // Unaligned start with a short head and tail.
    send_req(32'h0F0, 32'h1000, 32'h120, 1'b1, -1, 1'b0);
    drain("unaligned");

    // Zero-length transfer.
    send_req(32'h0000_0345, 32'h0000_0777, 32'd0, 1'b1, -1, 1'b0);
    drain("zero_len");
    check("zero_len_idle", 64'(req_ready_o), 64'd1);

    // Error on the middle of three chunks, then a clean follow-up.
    send_req(32'h0F0, 32'h1000, 32'h120, 1'b1, 1, 1'b0);
    send_req(32'h0F0, 32'h1000, 32'h120, 1'b1, -1, 1'b0);
    drain("error");

    // Backend silent: the outstanding limit caps issued chunks.
    base = n_chunks;
    pause = 1'b1;
    force_bready = 1'b1;
    send_req(32'h0, 32'h8000, 32'd4096, 1'b1, -1, 1'b0);
    repeat (30) @(negedge clk_i);
    check("stall_chunks", 64'(n_chunks - base), 64'd8);
    check("stall_valid",  64'(burst_req_valid_o), 64'd0);
    pause = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (burst_req_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    check("stall_resume", 64'(got), 64'd1);
    force_bready = 1'b0;
    drain("stall");

    // Downstream stalls the merged response; a new request still gets split.
    hold_rsp = 1'b1;
    force_bready = 1'b1;
    send_req(32'h0F0, 32'h1000, 32'h120, 1'b0, -1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) begin
        got = 1'b1;
        break;
      end
    end
    check("hold_rsp_valid",   64'(got), 64'd1);
    check("hold_brsp_ready",  64'(burst_rsp_ready_o), 64'd0);
    repeat (5) @(negedge clk_i);
    check("hold_rsp_kept",    64'(rsp_valid_o), 64'd1);
    check("hold_busy",        64'(busy_o), 64'd1);
    base = n_chunks;
    send_req(32'h0, 32'h2000, 32'd256, 1'b1, -1, 1'b0);
    repeat (10) @(negedge clk_i);
    check("hold_new_chunks",  64'(n_chunks - base), 64'd1);
    hold_rsp = 1'b0;
    force_bready = 1'b0;
    drain("hold");

    // Randomized traffic, including address wrap near the top of the space.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] s, d, l;
      s = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 + 32'($urandom_range(0, 255)) : $urandom;
      d = $urandom;
      l = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 1200));
      send_req(s, d, l, 1'($urandom_range(0, 1)), -1, 1'b1);
    end
    drain("random");

    check("end_req_ready",  64'(req_ready_o), 64'd1);
    check("end_exp_chunks", 64'(exp_chunks.size()), 64'd0);
    check("end_exp_rsps",   64'(exp_rsps.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
